// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR peripheral: register map, CTRL bit
// positions, global register addresses and the Galois step function.
package lfsr_pkg;

    // Register index inside a channel block; byte offset is index * 4.
    typedef enum logic [1:0] {
        REG_STATE = 2'd0,   // +0x0 RW
        REG_TAPS  = 2'd1,   // +0x4 RW
        REG_CTRL  = 2'd2,   // +0x8 RW
        REG_COUNT = 2'd3    // +0xC RO
    } reg_sel_e;

    // Byte stride between channel register blocks.
    localparam int CHAN_STRIDE = 16;

    // CTRL bit positions.
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_REQ_EN = 1;
    localparam int CTRL_STUCK  = 2;

    // Global registers (region-relative byte addresses, only [11:2] decoded).
    localparam logic [11:0] ADDR_STEP   = 12'h100;
    localparam logic [11:0] ADDR_STATUS = 12'h104;

    // STATUS layout: bit 0 is the synchronised request level,
    // per-channel STUCK flags start at this bit.
    localparam int STATUS_STUCK_LSB = 8;

    // Galois tap mask loaded at reset.
    localparam logic [31:0] DEFAULT_TAPS_C = 32'h0000_B400;

    // One right-shifting Galois step on a zero-extended state, masked to
    // the channel width. The all-zero fix-up is left to the caller.
    function automatic logic [31:0] galois_next(input logic [31:0] state,
                                                input logic [31:0] taps,
                                                input logic [31:0] mask);
        logic [31:0] nxt;
        nxt = (state >> 1) ^ (state[0] ? taps : 32'h0);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/lfsr_channel.sv
// One LFSR channel: state register, step counter and sticky STUCK flag.
// A load always beats a step in the same cycle.
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] taps,
    input  logic             step,
    input  logic             stuck_clr,
    output logic [WIDTH-1:0] state,
    output logic [31:0]      count,
    output logic             stuck
);

    localparam logic [31:0]      MASK = (WIDTH == 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << WIDTH) - 32'd1);
    localparam logic [WIDTH-1:0] ONE  = 1;

    logic [WIDTH-1:0] state_q, state_d;
    logic [31:0]      count_q, count_d;
    logic             stuck_q, stuck_d;
    logic [31:0]      step_raw;
    logic [WIDTH-1:0] step_val;

    // Next-state: load, step, or hold; a zero result is forced to 1 and flagged.
    always_comb begin
        step_raw = galois_next(32'(state_q), 32'(taps), MASK);
        step_val = step_raw[WIDTH-1:0];
        state_d  = state_q;
        count_d  = count_q;
        // A new stuck event in the same cycle as a clear wins over the clear.
        stuck_d  = stuck_q & ~stuck_clr;
        if (load) begin
            count_d = '0;
            if (load_val == '0) begin
                state_d = ONE;
                stuck_d = 1'b1;
            end else begin
                state_d = load_val;
            end
        end else if (step) begin
            count_d = count_q + 32'd1;
            if (step_val == '0) begin
                state_d = ONE;
                stuck_d = 1'b1;
            end else begin
                state_d = step_val;
            end
        end
    end

    // Channel registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ONE;
            count_q <= '0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stuck_q <= stuck_d;
        end
    end

    assign state = state_q;
    assign count = count_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/lfsr_pio.sv
// Bank of CHANNELS Galois LFSRs behind a simple memory-mapped register
// port, with an external asynchronous step request.
//
// Bus timing: there is no handshake. A write is accepted on every rising
// edge where we=1. Read data is produced every cycle: rd after an edge holds
// the register addressed during the previous cycle, as it was before any
// write on that same edge.
module lfsr_pio
    import lfsr_pkg::*;
#(
    parameter int          CHANNELS     = 4,
    parameter int          WIDTH        = 16,
    parameter logic [31:0] DEFAULT_TAPS = DEFAULT_TAPS_C
) (
    input  logic                clk,
    input  logic                reset,      // asynchronous, active low
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    input  logic                request,
    output logic [CHANNELS-1:0] lfsr_bit
);

    logic [WIDTH-1:0]    taps_q [CHANNELS];
    logic [CHANNELS-1:0] run_q, req_en_q;
    logic                req_s1_q, req_s2_q, req_s3_q;
    logic [31:0]         rd_q, rd_d;

    logic [WIDTH-1:0]    state_w [CHANNELS];
    logic [31:0]         count_w [CHANNELS];
    logic [CHANNELS-1:0] stuck_w;

    logic [CHANNELS-1:0] chan_sel, load, taps_wr, ctrl_wr, stuck_clr, step;
    logic                in_chan_region, step_wr, status_sel, req_edge;
    reg_sel_e            reg_sel;

    // Address bits outside [11:2] and unused data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[31:12], addr[1:0], wd};

    // Address decode and per-channel step/write strobes.
    always_comb begin
        in_chan_region = (addr[11:8] == 4'h0);
        reg_sel        = reg_sel_e'(addr[3:2]);
        step_wr        = we && (addr[11:2] == ADDR_STEP[11:2]);
        status_sel     = (addr[11:2] == ADDR_STATUS[11:2]);
        req_edge       = req_s2_q & ~req_s3_q;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_sel[c]  = in_chan_region && (addr[7:4] == c[3:0]);
            load[c]      = we && chan_sel[c] && (reg_sel == REG_STATE);
            taps_wr[c]   = we && chan_sel[c] && (reg_sel == REG_TAPS);
            ctrl_wr[c]   = we && chan_sel[c] && (reg_sel == REG_CTRL);
            stuck_clr[c] = ctrl_wr[c] && wd[CTRL_STUCK];
            step[c]      = run_q[c] | (step_wr & wd[c]) | (req_en_q[c] & req_edge);
        end
    end

    // TAPS/CTRL registers and the request synchroniser with edge-detect flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                taps_q[c] <= DEFAULT_TAPS[WIDTH-1:0];
            end
            run_q    <= '0;
            req_en_q <= '0;
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            req_s3_q <= 1'b0;
        end else begin
            req_s1_q <= request;
            req_s2_q <= req_s1_q;
            req_s3_q <= req_s2_q;
            for (int c = 0; c < CHANNELS; c++) begin
                if (taps_wr[c]) begin
                    taps_q[c] <= wd[WIDTH-1:0];
                end
                if (ctrl_wr[c]) begin
                    run_q[c]    <= wd[CTRL_RUN];
                    req_en_q[c] <= wd[CTRL_REQ_EN];
                end
            end
        end
    end

    // Channel instances.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        lfsr_channel #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .load      (load[g]),
            .load_val  (wd[WIDTH-1:0]),
            .taps      (taps_q[g]),
            .step      (step[g]),
            .stuck_clr (stuck_clr[g]),
            .state     (state_w[g]),
            .count     (count_w[g]),
            .stuck     (stuck_w[g])
        );
        assign lfsr_bit[g] = state_w[g][0];
    end

    // Read mux over pre-edge register values; unmapped space reads 0.
    always_comb begin
        rd_d = '0;
        if (status_sel) begin
            rd_d[0]                            = req_s2_q;
            rd_d[STATUS_STUCK_LSB +: CHANNELS] = stuck_w;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_sel[c]) begin
                case (reg_sel)
                    REG_STATE: rd_d[WIDTH-1:0] = state_w[c];
                    REG_TAPS:  rd_d[WIDTH-1:0] = taps_q[c];
                    REG_CTRL: begin
                        rd_d[CTRL_RUN]    = run_q[c];
                        rd_d[CTRL_REQ_EN] = req_en_q[c];
                        rd_d[CTRL_STUCK]  = stuck_w[c];
                    end
                    default:   rd_d = count_w[c];
                endcase
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_lfsr_pio.sv
// Self-checking bench for lfsr_pio (CHANNELS=4, WIDTH=16).
module tb_lfsr_pio;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic          request = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wd = '0;
    logic [31:0]   rd;
    logic [CH-1:0] lfsr_bit;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] m0, m1, m2;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    lfsr_pio #(.CHANNELS(CH), .WIDTH(16), .DEFAULT_TAPS(32'h0000_B400)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .request  (request),
        .lfsr_bit (lfsr_bit)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference Galois step with the zero fix-up.
    function automatic logic [15:0] galois16(input logic [15:0] s, input logic [15:0] t);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ t;
        if (n == 16'h0) n = 16'h1;
        return n;
    endfunction

    function automatic logic [31:0] ch_addr(input int ch, input int reg_idx);
        return 32'(ch * 16 + reg_idx * 4);
    endfunction

    // ---------------- drivers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        check_val(tag_q.pop_front(), rd, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_rd", rd, 32'h0);
        check_val("rst_lfsr_bit", 32'(lfsr_bit), 32'hF);
        reset = 1'b1;
        @(negedge clk);

        bus_read(ch_addr(0, 0), 32'h1, "rst_state");
        bus_read(ch_addr(0, 1), 32'hB400, "rst_taps");
        bus_read(ch_addr(0, 2), 32'h0, "rst_ctrl");
        bus_read(ch_addr(0, 3), 32'h0, "rst_count");

        // Single STEP on ch0 from 0xACE1.
        m0 = 16'hACE1;
        bus_write(ch_addr(0, 0), 32'(m0));
        bus_write(32'h100, 32'h1);
        m0 = galois16(m0, 16'hB400);
        bus_read(ch_addr(0, 0), 32'h0000_E270, "step_state");
        bus_read(ch_addr(0, 3), 32'h1, "step_count");

        // ch1 RUN for exactly 10 edges.
        m1 = 16'h1234;
        bus_write(ch_addr(1, 0), 32'(m1));
        bus_write(ch_addr(1, 2), 32'h1);
        idle(9);
        bus_write(ch_addr(1, 2), 32'h0);
        for (int i = 0; i < 10; i++) m1 = galois16(m1, 16'hB400);
        check_val("run_lfsr_bit", 32'(lfsr_bit[1]), 32'(m1[0]));
        bus_read(ch_addr(1, 3), 32'd10, "run_count");
        bus_read(ch_addr(1, 0), 32'(m1), "run_state");
        bus_read(ch_addr(0, 3), 32'h1, "run_other_count");

        // Stuck detection and write-1-to-clear.
        bus_write(ch_addr(1, 1), 32'h0);
        bus_write(ch_addr(1, 0), 32'h1);
        bus_write(32'h100, 32'h2);
        bus_read(ch_addr(1, 0), 32'h1, "stuck_state");
        bus_read(ch_addr(1, 2), 32'h4, "stuck_ctrl");
        bus_read(ch_addr(1, 3), 32'h1, "stuck_count");
        bus_read(32'h104, 32'h200, "stuck_status");
        bus_write(ch_addr(1, 2), 32'h4);
        bus_read(ch_addr(1, 2), 32'h0, "stuck_clr_ctrl");
        bus_read(32'h104, 32'h0, "stuck_clr_status");

        // Request-driven stepping on ch2, latency then 100 ns toggling.
        m2 = 16'h0002;
        bus_write(ch_addr(2, 0), 32'(m2));
        bus_write(ch_addr(2, 2), 32'h2);
        request = 1'b1;
        @(negedge clk);
        check_val("req_lat_e1", 32'(lfsr_bit[2]), 32'(m2[0]));
        @(negedge clk);
        check_val("req_lat_e2", 32'(lfsr_bit[2]), 32'(m2[0]));
        @(negedge clk);
        m2 = galois16(m2, 16'hB400);
        check_val("req_lat_e3", 32'(lfsr_bit[2]), 32'(m2[0]));
        bus_read(32'h104, 32'h1, "req_status_level");
        idle(1);
        for (int i = 0; i < 4; i++) begin
            request = 1'b0;
            idle(5);
            request = 1'b1;
            idle(5);
            m2 = galois16(m2, 16'hB400);
        end
        request = 1'b0;
        idle(3);
        bus_read(ch_addr(2, 3), 32'd5, "req_count");
        bus_read(ch_addr(2, 0), 32'(m2), "req_state");
        bus_read(ch_addr(3, 0), 32'h1, "req_idle_state");
        bus_read(ch_addr(3, 3), 32'h0, "req_idle_count");
        bus_read(ch_addr(1, 3), 32'h1, "req_ch1_count");
        bus_read(32'h104, 32'h0, "req_status_low");

        // STATE write coinciding with a request step on ch3.
        bus_write(ch_addr(2, 2), 32'h0);
        bus_write(ch_addr(3, 2), 32'h2);
        request = 1'b1;
        idle(2);
        bus_write(ch_addr(3, 0), 32'h5555);
        request = 1'b0;
        bus_read(ch_addr(3, 0), 32'h5555, "load_prio_state");
        bus_read(ch_addr(3, 3), 32'h0, "load_prio_count");
        bus_read(ch_addr(2, 3), 32'd5, "load_ch2_count");
        bus_write(ch_addr(3, 0), 32'h0);
        bus_read(ch_addr(3, 0), 32'h1, "load_zero_state");
        bus_read(ch_addr(3, 2), 32'h6, "load_zero_ctrl");
        bus_read(32'h104, 32'h800, "load_zero_status");
        bus_write(ch_addr(3, 2), 32'h4);
        bus_read(ch_addr(3, 2), 32'h0, "load_clr_ctrl");

        // Unmapped space, out-of-range channel, address aliasing.
        bus_read(32'h200, 32'h0, "unmap_200");
        bus_read(32'h100, 32'h0, "unmap_step_rd");
        bus_read(32'h040, 32'h0, "unmap_ch4");
        bus_write(32'h040, 32'h1111);
        bus_write(32'h200, 32'h2222);
        bus_read(ch_addr(0, 0), 32'(m0), "unmap_ch0_state");
        bus_read(32'h1000_0004, 32'hB400, "alias_taps");

        // Reset in the middle of a RUN.
        bus_write(ch_addr(0, 2), 32'h1);
        addr = ch_addr(0, 0);
        idle(4);
        #2 reset = 1'b0;
        #1;
        check_val("midrst_rd", rd, 32'h0);
        check_val("midrst_lfsr_bit", 32'(lfsr_bit), 32'hF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rel_lfsr_bit", 32'(lfsr_bit), 32'hF);
        bus_read(ch_addr(0, 0), 32'h1, "rel_state");
        bus_read(ch_addr(0, 2), 32'h0, "rel_ctrl");
        bus_read(ch_addr(0, 3), 32'h0, "rel_count");
        bus_read(ch_addr(1, 1), 32'hB400, "rel_taps");
        bus_read(ch_addr(2, 3), 32'h0, "rel_ch2_count");
        bus_read(32'h104, 32'h0, "rel_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
